// File: rtl/arbitro_escrita_reg.sv
// Register-file write-port arbiter for two writeback requesters (ALU, load).
// Define ARB_PRIO_FIXA_EN to give the load requester fixed priority instead of round-robin.
module arbitro_escrita_reg (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0_valid,
   input  logic [4:0]  req0_rd,
   input  logic [31:0] req0_data,
   output logic        req0_ready,
   input  logic        req1_valid,
   input  logic [4:0]  req1_rd,
   input  logic [31:0] req1_data,
   output logic        req1_ready,
   output logic        RegWrite,
   output logic [4:0]  WriteRegister,
   output logic [31:0] WriteData,
   output logic [15:0] conflitos
);

   logic        w_comp0;
   logic        w_comp1;
   logic        w_both;
   logic        w_grant0;
   logic        w_grant1;
`ifndef ARB_PRIO_FIXA_EN
   logic        r_ult_grant;
`endif
   logic        r_regwrite;
   logic [4:0]  r_wreg;
   logic [31:0] r_wdata;
   logic [15:0] r_conflitos;

   // Grant selection; writes to x0 are accepted outside the arbitration.
   always_comb begin
      w_comp0 = req0_valid && (req0_rd != 5'd0);
      w_comp1 = req1_valid && (req1_rd != 5'd0);
      w_both  = w_comp0 && w_comp1;
      if (w_both) begin
`ifdef ARB_PRIO_FIXA_EN
         w_grant0 = 1'b0;
         w_grant1 = 1'b1;
`else
         // Pointer holds the last winner, so the other side wins now.
         w_grant0 = r_ult_grant;
         w_grant1 = ~r_ult_grant;
`endif
      end else begin
         w_grant0 = w_comp0;
         w_grant1 = w_comp1;
      end
   end

   // Ready outputs, forced low while reset is held.
   always_comb begin
      if (reset) begin
         req0_ready = 1'b0;
         req1_ready = 1'b0;
      end else begin
         req0_ready = (req0_valid && (req0_rd == 5'd0)) || w_grant0;
         req1_ready = (req1_valid && (req1_rd == 5'd0)) || w_grant1;
      end
   end

   // Registered write port, priority pointer and contention counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_regwrite  <= 1'b0;
         r_wreg      <= 5'd0;
         r_wdata     <= 32'd0;
         r_conflitos <= 16'd0;
`ifndef ARB_PRIO_FIXA_EN
         r_ult_grant <= 1'b1;
`endif
      end else begin
         if (w_grant0) begin
            r_regwrite  <= 1'b1;
            r_wreg      <= req0_rd;
            r_wdata     <= req0_data;
`ifndef ARB_PRIO_FIXA_EN
            r_ult_grant <= 1'b0;
`endif
         end else if (w_grant1) begin
            r_regwrite  <= 1'b1;
            r_wreg      <= req1_rd;
            r_wdata     <= req1_data;
`ifndef ARB_PRIO_FIXA_EN
            r_ult_grant <= 1'b1;
`endif
         end else begin
            r_regwrite  <= 1'b0;
         end
         if (w_both && (r_conflitos != 16'hFFFF)) begin
            r_conflitos <= r_conflitos + 16'd1;
         end else begin
            r_conflitos <= r_conflitos;
         end
      end
   end

   assign RegWrite      = r_regwrite;
   assign WriteRegister = r_wreg;
   assign WriteData     = r_wdata;
   assign conflitos     = r_conflitos;

endmodule

// File: tb/tb_arbitro_escrita_reg.sv
// Directed bench for arbitro_escrita_reg; follows ARB_PRIO_FIXA_EN when defined.
module tb_arbitro_escrita_reg;

`ifdef ARB_PRIO_FIXA_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        req0_valid, req1_valid;
   logic [4:0]  req0_rd, req1_rd;
   logic [31:0] req0_data, req1_data;
   logic        req0_ready, req1_ready;
   logic        RegWrite;
   logic [4:0]  WriteRegister;
   logic [31:0] WriteData;
   logic [15:0] conflitos;
   int          tests = 0;
   int          failed = 0;

   arbitro_escrita_reg dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_rd(req0_rd), .req0_data(req0_data), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_rd(req1_rd), .req1_data(req1_data), .req1_ready(req1_ready),
      .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
      .conflitos(conflitos)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
         $error("check %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      req0_valid = 1'b0; req0_rd = 5'd0; req0_data = 32'd0;
      req1_valid = 1'b0; req1_rd = 5'd0; req1_data = 32'd0;
   endtask

   task automatic drive0(input logic [4:0] rd, input logic [31:0] d);
      req0_valid = 1'b1; req0_rd = rd; req0_data = d;
   endtask

   task automatic drive1(input logic [4:0] rd, input logic [31:0] d);
      req1_valid = 1'b1; req1_rd = rd; req1_data = d;
   endtask

   initial begin
      logic [1:0] exp_rdy;
      reset = 1'b1;
      idle();
      #2;
      check("rst_regwrite", {31'd0, RegWrite}, 32'd0);
      check("rst_wreg", {27'd0, WriteRegister}, 32'd0);
      check("rst_wdata", WriteData, 32'd0);
      check("rst_conflitos", {16'd0, conflitos}, 32'd0);
      drive0(5'd5, 32'h1); drive1(5'd7, 32'h2);
      #1;
      check("rst_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
      idle();
      tick();
      reset = 1'b0;

      // single ALU write
      drive0(5'd5, 32'hAAAA0001);
      #1;
      check("single_ready", {30'd0, req0_ready, req1_ready}, {30'd0, 2'b10});
      tick();
      idle();
      check("single_regwrite", {31'd0, RegWrite}, 32'd1);
      check("single_wreg", {27'd0, WriteRegister}, 32'd5);
      check("single_wdata", WriteData, 32'hAAAA0001);
      tick();
      check("idle_regwrite", {31'd0, RegWrite}, 32'd0);
      check("idle_hold_wreg", {27'd0, WriteRegister}, 32'd5);

      // x0 write is accepted but never reaches the register file
      drive0(5'd0, 32'h12345678);
      #1;
      check("x0_ready", {31'd0, req0_ready}, 32'd1);
      tick();
      idle();
      check("x0_regwrite", {31'd0, RegWrite}, 32'd0);
      check("x0_hold_wdata", WriteData, 32'hAAAA0001);

      // asynchronous reset between edges
      #2 reset = 1'b1;
      #1;
      check("arst_wreg", {27'd0, WriteRegister}, 32'd0);
      check("arst_wdata", WriteData, 32'd0);
      tick();
      reset = 1'b0;

`ifndef ARB_PRIO_FIXA_EN
      // first contention after reset goes to req0, then req1
      drive0(5'd3, 32'h33); drive1(5'd4, 32'h44);
      #1;
      check("c1_ready", {30'd0, req0_ready, req1_ready}, {30'd0, 2'b10});
      tick();
      req0_valid = 1'b0;
      check("c1_wreg", {27'd0, WriteRegister}, 32'd3);
      check("c1_wdata", WriteData, 32'h33);
      check("c1_conflitos", {16'd0, conflitos}, 32'd1);
      check("c2_ready", {30'd0, req0_ready, req1_ready}, {30'd0, 2'b01});
      tick();
      idle();
      check("c2_regwrite", {31'd0, RegWrite}, 32'd1);
      check("c2_wreg", {27'd0, WriteRegister}, 32'd4);
      check("c2_wdata", WriteData, 32'h44);
      check("c2_conflitos", {16'd0, conflitos}, 32'd1);

      // x0 from req0 alongside a real write from req1
      drive0(5'd0, 32'hDEAD); drive1(5'd7, 32'h77);
      #1;
      check("x0mix_ready", {30'd0, req0_ready, req1_ready}, {30'd0, 2'b11});
      tick();
      idle();
      check("x0mix_wreg", {27'd0, WriteRegister}, 32'd7);
      check("x0mix_wdata", WriteData, 32'h77);
      check("x0mix_conflitos", {16'd0, conflitos}, 32'd1);

      // last winner was req1, so req0 wins next
      drive0(5'd10, 32'hA); drive1(5'd11, 32'hB);
      #1;
      check("c3_ready", {30'd0, req0_ready, req1_ready}, {30'd0, 2'b10});
      tick();
      req0_valid = 1'b0;
      check("c3_wreg", {27'd0, WriteRegister}, 32'd10);
      tick();
      idle();
      check("c4_wreg", {27'd0, WriteRegister}, 32'd11);
      check("c4_conflitos", {16'd0, conflitos}, 32'd2);

      // same destination from both sides is serialised
      drive0(5'd6, 32'h61); drive1(5'd6, 32'h62);
      #1;
      tick();
      req0_valid = 1'b0;
      check("same1_wdata", WriteData, 32'h61);
      tick();
      idle();
      check("same2_wreg", {27'd0, WriteRegister}, 32'd6);
      check("same2_wdata", WriteData, 32'h62);
      check("same_conflitos", {16'd0, conflitos}, 32'd3);
`else
      // fixed load priority: req1 wins every contended cycle
      drive0(5'd2, 32'h22); drive1(5'd9, 32'h99);
      #1;
      for (int k = 0; k < 3; k++) begin
         check("fix_ready", {30'd0, req0_ready, req1_ready}, {30'd0, 2'b01});
         tick();
         check("fix_regwrite", {31'd0, RegWrite}, 32'd1);
         check("fix_wreg", {27'd0, WriteRegister}, 32'd9);
         check("fix_wdata", WriteData, 32'h99);
      end
      idle();
      check("fix_conflitos", {16'd0, conflitos}, 32'd3);
      tick();
`endif

      // pending write dropped by reset; pointer returns to favour req0
      drive0(5'd15, 32'hF);
      #1;
      tick();
      idle();
      check("pre_drop_wreg", {27'd0, WriteRegister}, 32'd15);
      drive0(5'd12, 32'hC);
      #1;
      check("drop_ready_before", {31'd0, req0_ready}, 32'd1);
      #2 reset = 1'b1;
      #1;
      check("drop_regwrite", {31'd0, RegWrite}, 32'd0);
      check("drop_ready", {31'd0, req0_ready}, 32'd0);
      tick();
      idle();
      reset = 1'b0;
      check("drop_wreg", {27'd0, WriteRegister}, 32'd0);
      tick();
      check("drop_after_regwrite", {31'd0, RegWrite}, 32'd0);
      drive0(5'd13, 32'hD); drive1(5'd14, 32'hE);
      #1;
      exp_rdy = FIXED ? 2'b01 : 2'b10;
      check("drop_next_grant", {30'd0, req0_ready, req1_ready}, {30'd0, exp_rdy});
      idle();
      tick();

      // long contention: alternating grants and counter saturation
      reset = 1'b1;
      #1 reset = 1'b0;
      drive0(5'd1, 32'h1); drive1(5'd2, 32'h2);
      #1;
      for (int i = 0; i < 70000; i++) begin
         exp_rdy = (FIXED || (i % 2 == 1)) ? 2'b01 : 2'b10;
         check("sat_ready", {30'd0, req0_ready, req1_ready}, {30'd0, exp_rdy});
         if (i == 65534) begin
            check("sat_pre", {16'd0, conflitos}, 32'h0000FFFE);
         end
         tick();
      end
      idle();
      check("sat_conflitos", {16'd0, conflitos}, 32'h0000FFFF);
      check("sat_regwrite", {31'd0, RegWrite}, 32'd1);
      check("sat_wreg", {27'd0, WriteRegister}, 32'd2);
      tick();
      check("sat_hold", {16'd0, conflitos}, 32'h0000FFFF);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
